calc_key_sequencer: RTL and testbench

//  Sequencing controller for the keypad calculator. Consumes decoded key codes
//  one per handshake, runs the entry FSM (sign, up to MAX_DIGITS decimal digits,

---
 rtl/calc_key_sequencer_if.sv | 26 ++
 rtl/calc_key_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/calc_key_sequencer_if.sv
// Key handshake and result bundle for the calculator sequencer.
// master: key source / result sink; slave: the sequencer.
interface calc_key_sequencer_if #(
  parameter int DW = 11
);
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_ready;
  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          div_zero;
  logic          ovf;

  modport master (
    output key_valid, key_code,
    input  key_ready, busy, result,
    input  result_valid, div_zero, ovf
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, busy, result,
    output result_valid, div_zero, ovf
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Keypad calculator sequencer: entry FSM plus multi-cycle signed ALU.
// Ports: clk, rst (sync, active-high), kif (slave: keys in, result out).
module calc_key_sequencer #(
  parameter int DW         = 11,
  parameter int MAX_DIGITS = 3
) (
  input logic                 clk,
  input logic                 rst,
  calc_key_sequencer_if.slave kif
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int YW = $clog2(DW);
  localparam int XW = 2 * DW + 2;
  localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);
  localparam logic [YW-1:0] LAST = YW'(DW - 1);

  typedef enum logic [2:0] {
    S_SIGN1, S_DIG1, S_SIGN2, S_DIG2, S_EXEC, S_DONE
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  state_e          state_q, state_d, st;
  logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic            neg1_q, neg1_d, neg2_q, neg2_d;
  logic [CW-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [1:0]      opr_q, opr_d;
  logic [YW-1:0]   cyc_q, cyc_d;
  logic [2*DW-1:0] prod_q, prod_d, prod_nxt;
  logic [DW-1:0]   rem_q, rem_d, rem_nxt;
  logic [DW-1:0]   quo_q, quo_d, quo_nxt;
  logic [DW-1:0]   res_q, res_d;
  logic            rv_q, rv_d, dz_q, dz_d, ovf_q, ovf_d;

  logic            accept, is_dig, is_pm, is_op;
  logic [DW:0]     rsh;
  logic            ge;
  logic [XW-1:0]   a_x, b_x, ex;
  logic            fits, neg_r;
  logic [DW-1:0]   acc1, acc2, dval;

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    opr_d   = opr_q;
    cyc_d   = cyc_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    rv_d    = rv_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    // one restoring-divide step on magnitudes
    rsh     = {rem_q, quo_q[DW-1]};
    ge      = rsh >= {1'b0, op2_q};
    rem_nxt = DW'(ge ? rsh - {1'b0, op2_q} : rsh);
    quo_nxt = {quo_q[DW-2:0], ge};

    // one shift-add multiply step, bit cyc of op2
    prod_nxt = prod_q + (op2_q[cyc_q]
             ? ({{DW{1'b0}}, op1_q} << cyc_q)
             : '0);

    a_x = XW'(op1_q);
    if (neg1_q) a_x = -a_x;
    b_x = XW'(op2_q);
    if (neg2_q) b_x = -b_x;
    neg_r = neg1_q ^ neg2_q;

    unique case (opr_q)
      OP_ADD:  ex = a_x + b_x;
      OP_SUB:  ex = a_x - b_x;
      OP_MUL:  ex = neg_r ? -XW'(prod_nxt) : XW'(prod_nxt);
      default: ex = neg_r ? -XW'(quo_nxt) : XW'(quo_nxt);
    endcase
    // representable iff top bits are pure sign extension
    fits = (&ex[XW-1:DW-1]) | ~(|ex[XW-1:DW-1]);

    accept = kif.key_valid & (state_q != S_EXEC);
    is_dig = kif.key_code <= 4'd9;
    is_pm  = (kif.key_code == 4'd10) | (kif.key_code == 4'd11);
    is_op  = is_pm | (kif.key_code == 4'd12)
           | (kif.key_code == 4'd13);
    dval   = {{(DW-4){1'b0}}, kif.key_code};
    acc1   = (op1_q << 3) + (op1_q << 1) + dval;
    acc2   = (op2_q << 3) + (op2_q << 1) + dval;

    // DONE handles keys exactly like SIGN1
    st = (state_q == S_DONE) ? S_SIGN1 : state_q;

    if (state_q == S_EXEC) begin
      if (opr_q == OP_ADD || opr_q == OP_SUB) begin
        res_d   = ex[DW-1:0];
        ovf_d   = ~fits;
        dz_d    = 1'b0;
        rv_d    = 1'b1;
        state_d = S_DONE;
      end else if (opr_q == OP_MUL) begin
        prod_d = prod_nxt;
        cyc_d  = cyc_q + YW'(1);
        if (cyc_q == LAST) begin
          res_d   = ex[DW-1:0];
          ovf_d   = ~fits;
          dz_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end
      end else if (op2_q == '0) begin
        res_d   = '0;
        ovf_d   = 1'b0;
        dz_d    = 1'b1;
        rv_d    = 1'b1;
        state_d = S_DONE;
      end else begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cyc_d = cyc_q + YW'(1);
        if (cyc_q == LAST) begin
          res_d   = ex[DW-1:0];
          ovf_d   = ~fits;
          dz_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end
      end
    end else if (accept) begin
      rv_d  = 1'b0;
      dz_d  = 1'b0;
      ovf_d = 1'b0;
      if (kif.key_code == 4'd15) begin
        state_d = S_SIGN1;
        op1_d   = '0;
        op2_d   = '0;
        neg1_d  = 1'b0;
        neg2_d  = 1'b0;
        cnt1_d  = '0;
        cnt2_d  = '0;
        opr_d   = '0;
        cyc_d   = '0;
        prod_d  = '0;
        rem_d   = '0;
        quo_d   = '0;
        res_d   = '0;
      end else begin
        unique case (st)
          S_SIGN1: begin
            state_d = S_SIGN1;
            if (is_dig) begin
              neg1_d  = 1'b0;
              op1_d   = dval;
              cnt1_d  = CW'(1);
              state_d = S_DIG1;
            end else if (is_pm) begin
              neg1_d  = kif.key_code[0];
              op1_d   = '0;
              cnt1_d  = '0;
              state_d = S_DIG1;
            end
          end
          S_DIG1: begin
            if (is_dig) begin
              if (cnt1_q < MAXC) begin
                op1_d  = acc1;
                cnt1_d = cnt1_q + CW'(1);
              end
            end else if (is_op) begin
              opr_d   = 2'(kif.key_code - 4'd10);
              op2_d   = '0;
              neg2_d  = 1'b0;
              cnt2_d  = '0;
              state_d = S_SIGN2;
            end
          end
          S_SIGN2: begin
            if (is_dig) begin
              neg2_d  = 1'b0;
              op2_d   = dval;
              cnt2_d  = CW'(1);
              state_d = S_DIG2;
            end else if (is_pm) begin
              neg2_d  = kif.key_code[0];
              op2_d   = '0;
              cnt2_d  = '0;
              state_d = S_DIG2;
            end
          end
          S_DIG2: begin
            if (is_dig) begin
              if (cnt2_q < MAXC) begin
                op2_d  = acc2;
                cnt2_d = cnt2_q + CW'(1);
              end
            end else if (kif.key_code == 4'd14) begin
              cyc_d   = '0;
              prod_d  = '0;
              rem_d   = '0;
              quo_d   = op1_q;
              state_d = S_EXEC;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SIGN1;
      op1_q   <= '0;
      op2_q   <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      opr_q   <= '0;
      cyc_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      opr_q   <= opr_d;
      cyc_q   <= cyc_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign kif.key_ready    = (state_q != S_EXEC);
  assign kif.busy         = (state_q == S_EXEC);
  assign kif.result       = res_q;
  assign kif.result_valid = rv_q;
  assign kif.div_zero     = dz_q;
  assign kif.ovf          = ovf_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer.
// Key strings are hex nibbles: A + B - C * D / E = F clear.
module tb_calc_key_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  calc_key_sequencer_if #(.DW(11)) kif ();

  calc_key_sequencer #(
    .DW(11),
    .MAX_DIGITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    int n;
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = c;
    n = 0;
    while (!kif.key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100)
      chk("press_ready", {31'd0, kif.key_ready}, 32'd1);
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
  endtask

  task automatic enter(input logic [63:0] s, input int len);
    for (int i = 0; i < len; i++)
      press(s[4*(len-1-i) +: 4]);
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (!kif.result_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [63:0] s, input int len,
                     input int lat, input logic [10:0] res,
                     input logic ov, input logic dz);
    int n;
    enter(s, len);
    chk({tag, "_busy"}, {31'd0, kif.busy}, 32'd1);
    chk({tag, "_rv0"}, {31'd0, kif.result_valid}, 32'd0);
    wait_rv(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, {21'd0, kif.result}, {21'd0, res});
    chk({tag, "_ovf"}, {31'd0, kif.ovf}, {31'd0, ov});
    chk({tag, "_dz"}, {31'd0, kif.div_zero}, {31'd0, dz});
    chk({tag, "_idle"}, {31'd0, kif.busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, kif.key_ready}, 32'd1);
    chk("rst_busy", {31'd0, kif.busy}, 32'd0);
    chk("rst_res", {21'd0, kif.result}, 32'd0);
    chk("rst_rv", {31'd0, kif.result_valid}, 32'd0);
    chk("rst_dz", {31'd0, kif.div_zero}, 32'd0);
    chk("rst_ovf", {31'd0, kif.ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("add42", 64'h12A30E, 6, 1, 11'h02A, 1'b0, 1'b0);
    run("mul_m35", 64'hB5C7E, 5, 11, 11'h7DD, 1'b0, 1'b0);
    run("div_m3", 64'hB7D2E, 5, 11, 11'h7FD, 1'b0, 1'b0);
    run("div0", 64'h100D0E, 6, 1, 11'h000, 1'b0, 1'b1);

    enter(64'h7, 1);
    chk("done_key_rv", {31'd0, kif.result_valid}, 32'd0);
    chk("done_key_dz", {31'd0, kif.div_zero}, 32'd0);
    run("done_op1", 64'hA3E, 3, 1, 11'h00A, 1'b0, 1'b0);

    run("dig4", 64'h1234A1E, 7, 1, 11'h07C, 1'b0, 1'b0);
    run("mul_ovf", 64'h999C999E, 8, 11, 11'h271, 1'b1, 1'b0);
    run("add_max", 64'h999A24E, 7, 1, 11'h3FF, 1'b0, 1'b0);
    run("sub_ovf", 64'hB999B999E, 9, 1, 11'h032, 1'b1, 1'b0);
    run("neg2", 64'h5BB3E, 5, 1, 11'h008, 1'b0, 1'b0);
    run("ign_mul", 64'hC6A1E, 5, 1, 11'h007, 1'b0, 1'b0);

    run("clr_pre", 64'h2A2E, 4, 1, 11'h004, 1'b0, 1'b0);
    press(4'hF);
    chk("clr_res", {21'd0, kif.result}, 32'd0);
    chk("clr_rv", {31'd0, kif.result_valid}, 32'd0);
    run("clr_post", 64'h4B6E, 4, 1, 11'h7FE, 1'b0, 1'b0);
    enter(64'h5AF, 3);
    run("clr_mid", 64'h1A1E, 4, 1, 11'h002, 1'b0, 1'b0);

    enter(64'hB5C7E, 5);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = 4'd4;
    chk("hold_ready", {31'd0, kif.key_ready}, 32'd0);
    chk("hold_busy", {31'd0, kif.busy}, 32'd1);
    wait_rv(n);
    chk("hold_lat", n, 11);
    chk("hold_res", {21'd0, kif.result}, 32'h7DD);
    chk("hold_ready2", {31'd0, kif.key_ready}, 32'd1);
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
    chk("hold_taken", {31'd0, kif.result_valid}, 32'd0);
    run("hold_op1", 64'hA1E, 3, 1, 11'h005, 1'b0, 1'b0);

    enter(64'h9C9E, 4);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rstx_busy0", {31'd0, kif.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstx_busy", {31'd0, kif.busy}, 32'd0);
    chk("rstx_ready", {31'd0, kif.key_ready}, 32'd1);
    chk("rstx_res", {21'd0, kif.result}, 32'd0);
    chk("rstx_rv", {31'd0, kif.result_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 64'h3C3E, 4, 11, 11'h009, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
